// File: rtl/systolic_fir_reload.sv
// Streaming TAP-tap signed FIR with a double-buffered, runtime-reloadable
// coefficient bank and a fixed 3-stage multiply / sum / round-saturate pipeline.
module systolic_fir_reload #(
    parameter int                   TAP      = 4,
    parameter int                   XIN_W    = 16,
    parameter int                   COE_W    = 16,
    parameter int                   ACC_W    = 48,
    parameter int                   YOUT_W   = 25,
    parameter int                   SHIFT    = 0,
    // {129, -138, 14, 7} with h0 in the LSBs
    parameter logic [TAP*COE_W-1:0] COE_INIT = 64'h0081_FF76_000E_0007
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     x_vld,
    input  logic signed [XIN_W-1:0]  x_in,
    input  logic                     coe_wr,
    input  logic [$clog2(TAP)-1:0]   coe_addr,
    input  logic signed [COE_W-1:0]  coe_data,
    input  logic                     coe_swap,
    output logic                     y_vld,
    output logic signed [YOUT_W-1:0] y_out,
    output logic                     y_sat
);

    localparam int             PROD_W = XIN_W + COE_W;
    localparam logic [ACC_W:0] RND    = ((ACC_W+1)'(1) << SHIFT) >> 1;

    if (TAP < 2) begin : g_chk_tap
        $error("systolic_fir_reload: TAP must be at least 2");
    end
    if (ACC_W < PROD_W + $clog2(TAP)) begin : g_chk_acc
        $error("systolic_fir_reload: ACC_W too narrow for full-precision sum");
    end
    if (YOUT_W > ACC_W) begin : g_chk_yout
        $error("systolic_fir_reload: YOUT_W must not exceed ACC_W");
    end

    logic signed [COE_W-1:0]  act_q  [TAP];
    logic signed [COE_W-1:0]  shd_q  [TAP];
    logic signed [XIN_W-1:0]  hist_q [TAP];
    logic signed [XIN_W-1:0]  hist_d [TAP];

    logic                     s1_vld_q;
    logic signed [XIN_W-1:0]  s1_x_q [TAP];
    logic signed [COE_W-1:0]  s1_h_q [TAP];
    logic                     s2_vld_q;
    logic signed [PROD_W-1:0] s2_p_q [TAP];

    logic signed [ACC_W-1:0]  acc_c;
    logic signed [ACC_W:0]    rnd_c;
    logic signed [ACC_W:0]    r_c;
    logic                     fits_c;
    logic signed [YOUT_W-1:0] y_d;
    logic                     sat_d;

    logic                     y_vld_q;
    logic signed [YOUT_W-1:0] y_out_q;
    logic                     y_sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAP; k++) begin
                act_q[k] <= COE_INIT[k*COE_W +: COE_W];
                shd_q[k] <= COE_INIT[k*COE_W +: COE_W];
            end
        end else begin
            // NOTE: non-blocking assignments make the swap copy the shadow bank
            // as it stood before this edge, so a same-cycle write never reaches
            // the active bank.
            if (coe_swap) act_q <= shd_q;
            if (coe_wr) shd_q[coe_addr] <= coe_data;
        end
    end

    // History as it will look once the current sample is accepted.
    always_comb begin
        hist_d[0] = x_in;
        for (int k = 1; k < TAP; k++) hist_d[k] = hist_q[k-1];
    end

    // Stage 1: history plus a snapshot of the bank in force for this sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q   <= '{default: '0};
            s1_vld_q <= 1'b0;
            s1_x_q   <= '{default: '0};
            s1_h_q   <= '{default: '0};
        end else begin
            s1_vld_q <= x_vld;
            if (x_vld) begin
                hist_q <= hist_d;
                s1_x_q <= hist_d;
                s1_h_q <= act_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            s2_p_q   <= '{default: '0};
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                for (int k = 0; k < TAP; k++) s2_p_q[k] <= s1_x_q[k] * s1_h_q[k];
            end
        end
    end

    // Sum at full precision, round half up, then clip when the upper bits
    // above the output sign bit are not a pure sign extension.
    always_comb begin
        acc_c = '0;
        for (int k = 0; k < TAP; k++) begin
            acc_c = acc_c + {{(ACC_W-PROD_W){s2_p_q[k][PROD_W-1]}}, s2_p_q[k]};
        end
        rnd_c  = {acc_c[ACC_W-1], acc_c} + RND;
        r_c    = rnd_c >>> SHIFT;
        fits_c = (&r_c[ACC_W:YOUT_W-1]) | ~(|r_c[ACC_W:YOUT_W-1]);
        sat_d  = ~fits_c;
        if (fits_c) begin
            y_d = r_c[YOUT_W-1:0];
        end else if (r_c[ACC_W]) begin
            y_d = {1'b1, {(YOUT_W-1){1'b0}}};
        end else begin
            y_d = {1'b0, {(YOUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_vld_q <= 1'b0;
            y_out_q <= '0;
            y_sat_q <= 1'b0;
        end else begin
            y_vld_q <= s2_vld_q;
            y_sat_q <= s2_vld_q & sat_d;
            if (s2_vld_q) y_out_q <= y_d;
        end
    end

    assign y_vld = y_vld_q;
    assign y_out = y_out_q;
    assign y_sat = y_sat_q;

endmodule

// File: tb/tb_systolic_fir_reload.sv
// Directed bench for systolic_fir_reload: impulse, bubbles, rounding,
// saturation, coefficient swap boundary and mid-stream reset.
module tb_systolic_fir_reload;

    localparam int XIN_W  = 16;
    localparam int COE_W  = 16;
    localparam int YOUT_W = 25;
    localparam int N      = 12;
    localparam int Y_MAX  = 16777215;
    localparam int Y_MIN  = -16777216;

    logic                     clk;
    logic                     rst_n;
    logic                     x_vld;
    logic signed [XIN_W-1:0]  x_in;
    logic                     coe_wr;
    logic [1:0]               coe_addr;
    logic signed [COE_W-1:0]  coe_data;
    logic                     coe_swap;
    logic                     y_vld, yr_vld;
    logic signed [YOUT_W-1:0] y_out, yr_out;
    logic                     y_sat, yr_sat;

    int n_vec, n_miss;
    int y_hold, r_hold;
    bit chk_r;
    int t_vld[N], t_x[N], t_swp[N], t_wr[N], t_dat[N];
    int t_ev[N], t_ey[N], t_es[N], t_er[N];

    systolic_fir_reload dut (
        .clk(clk), .rst_n(rst_n), .x_vld(x_vld), .x_in(x_in),
        .coe_wr(coe_wr), .coe_addr(coe_addr), .coe_data(coe_data), .coe_swap(coe_swap),
        .y_vld(y_vld), .y_out(y_out), .y_sat(y_sat)
    );

    systolic_fir_reload #(.SHIFT(4)) dut_r (
        .clk(clk), .rst_n(rst_n), .x_vld(x_vld), .x_in(x_in),
        .coe_wr(coe_wr), .coe_addr(coe_addr), .coe_data(coe_data), .coe_swap(coe_swap),
        .y_vld(yr_vld), .y_out(yr_out), .y_sat(yr_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tab();
        t_vld = '{default: 0}; t_x  = '{default: 0}; t_swp = '{default: 0};
        t_wr  = '{default: 0}; t_dat = '{default: 0};
        t_ev  = '{default: 0}; t_ey = '{default: 0}; t_es  = '{default: 0};
        t_er  = '{default: 0};
    endtask

    // One table row per cycle: drive inputs, compare this cycle's outputs.
    task automatic run_table(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            x_vld    = (t_vld[c] != 0);
            x_in     = XIN_W'(t_x[c]);
            coe_swap = (t_swp[c] != 0);
            coe_wr   = (t_wr[c] != 0);
            coe_addr = '0;
            coe_data = COE_W'(t_dat[c]);
            if (t_ev[c] != 0) y_hold = t_ey[c];
            check($sformatf("%s[%0d].y_vld", tag, c), y_vld, t_ev[c] != 0);
            check($sformatf("%s[%0d].y_out", tag, c), y_out, y_hold);
            check($sformatf("%s[%0d].y_sat", tag, c), y_sat, (t_ev[c] != 0) && (t_es[c] != 0));
            if (chk_r) begin
                if (t_ev[c] != 0) r_hold = t_er[c];
                check($sformatf("%s[%0d].rnd_vld", tag, c), yr_vld, t_ev[c] != 0);
                check($sformatf("%s[%0d].rnd_out", tag, c), yr_out, r_hold);
            end
            step();
        end
        x_vld    = 1'b0;
        coe_swap = 1'b0;
        coe_wr   = 1'b0;
    endtask

    task automatic write_coe(input logic [1:0] a, input int d);
        coe_wr   = 1'b1;
        coe_addr = a;
        coe_data = COE_W'(d);
        step();
        coe_wr   = 1'b0;
    endtask

    task automatic swap_pulse();
        coe_swap = 1'b1;
        step();
        coe_swap = 1'b0;
    endtask

    task automatic flush();
        x_vld = 1'b1;
        x_in  = '0;
        repeat (4) step();
        x_vld = 1'b0;
        repeat (4) step();
        y_hold = 0;
        r_hold = 0;
    endtask

    task automatic load_impulse();
        clear_tab();
        t_vld = '{1,1,1,1,1,0,0,0,0,0,0,0};
        t_x   = '{1,0,0,0,0,0,0,0,0,0,0,0};
        t_ev  = '{0,0,0,1,1,1,1,1,0,0,0,0};
        t_ey  = '{0,0,0,7,14,-138,129,0,0,0,0,0};
        t_er  = '{0,0,0,0,1,-9,8,0,0,0,0,0};
    endtask

    initial begin
        n_vec = 0; n_miss = 0; y_hold = 0; r_hold = 0; chk_r = 1'b0;
        rst_n = 1'b0; x_vld = 1'b0; x_in = '0;
        coe_wr = 1'b0; coe_addr = '0; coe_data = '0; coe_swap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.y_vld", y_vld, 0);
        check("rst.y_out", y_out, 0);
        check("rst.y_sat", y_sat, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Impulse through default taps; SHIFT=4 instance checked alongside.
        load_impulse();
        chk_r = 1'b1;
        run_table(9, "imp");
        chk_r = 1'b0;

        // Step with bubbles; junk x_in on idle cycles must not enter history.
        clear_tab();
        t_vld = '{1,0,1,0,1,0,1,0,1,0,0,0};
        t_x   = '{1,99,1,99,1,99,1,99,1,99,0,0};
        t_ev  = '{0,0,0,1,0,1,0,1,0,1,0,1};
        t_ey  = '{0,0,0,7,0,21,0,-117,0,12,0,12};
        run_table(12, "step");

        // Swap boundary, write-during-swap exclusion, repeated swap.
        flush();
        write_coe(2'd0, 1);
        write_coe(2'd1, 0);
        write_coe(2'd2, 0);
        write_coe(2'd3, 0);
        clear_tab();
        t_vld = '{1,1,0,1,0,1,0,1,0,0,0,0};
        t_x   = '{5,5,0,5,0,5,0,5,0,0,0,0};
        t_swp = '{1,0,1,0,1,0,1,0,0,0,0,0};
        t_wr  = '{0,0,1,0,0,0,0,0,0,0,0,0};
        t_dat = '{0,0,2,0,0,0,0,0,0,0,0,0};
        t_ev  = '{0,0,0,1,1,0,1,0,1,0,1,0};
        t_ey  = '{0,0,0,35,5,0,5,0,10,0,10,0};
        run_table(12, "swap");

        // Saturation both ways, with one in-range result between them.
        flush();
        for (int k = 0; k < 4; k++) write_coe(2'(k), 32767);
        swap_pulse();
        clear_tab();
        t_vld = '{1,1,1,1,1,1,1,1,0,0,0,0};
        t_x   = '{-32768,-32768,-32768,-32768,32767,32767,32767,32767,0,0,0,0};
        t_ev  = '{0,0,0,1,1,1,1,1,1,1,1,0};
        t_ey  = '{0,0,0,Y_MIN,Y_MIN,Y_MIN,Y_MIN,Y_MIN,-65534,Y_MAX,Y_MAX,0};
        t_es  = '{0,0,0,1,1,1,1,1,0,1,1,0};
        run_table(12, "sat");

        // Reset with one output visible and two more in flight.
        x_vld = 1'b1;
        x_in  = 16'sd1;
        repeat (3) step();
        x_vld = 1'b0;
        check("mid.pre_vld", y_vld, 1);
        check("mid.pre_out", y_out, Y_MAX);
        #2 rst_n = 1'b0;
        #1;
        check("mid.rst_vld", y_vld, 0);
        check("mid.rst_out", y_out, 0);
        check("mid.rst_sat", y_sat, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        y_hold = 0;
        r_hold = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("mid.post[%0d].y_vld", c), y_vld, 0);
        end

        load_impulse();
        chk_r = 1'b1;
        run_table(9, "imp2");
        chk_r = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/systolic_fir_reload.md
Name: systolic_fir_reload

Overview:
- Parametrised next-generation FIR: TAP-tap, signed, streaming, with runtime-reloadable coefficients and round/saturate output.
- Double-buffered coefficient bank: a host writes the shadow bank, then a swap pulse makes it active on a clean sample boundary.
- Sits between a sample source (x_vld strobe, no back-pressure) and downstream DSP logic.
- Reset coefficients default to the team's standard 4-tap set.

Parameters:
- TAP, 4, number of taps (>=2).
- XIN_W, 16, signed width of x(n).
- COE_W, 16, signed width of h(k).
- ACC_W, 48, accumulator width; must be >= XIN_W+COE_W+clog2(TAP). Elaboration error otherwise.
- YOUT_W, 25, signed width of y(n).
- SHIFT, 0, arithmetic right shift applied before saturation; 0 = no rounding.
- COE_INIT, {129,-138,14,7}, packed TAP*COE_W reset coefficients; h0 is in the LSBs.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x_vld  in  1  sample strobe; x_in accepted on every cycle it is high.
- x_in  in  XIN_W  signed sample.
- coe_wr  in  1  write strobe into the shadow bank.
- coe_addr  in  clog2(TAP)  tap index k.
- coe_data  in  COE_W  signed coefficient h(k).
- coe_swap  in  1  pulse: copy the shadow bank into the active bank.
- y_vld  out  1  output strobe.
- y_out  out  YOUT_W  signed filtered sample.
- y_sat  out  1  high with y_vld when y_out was clipped.

Behaviour:
- Reset (async assert, sync release):
  - Active and shadow banks = COE_INIT.
  - Sample history = 0.
  - Pipeline valid bits = 0.
  - y_vld = 0, y_out = 0, y_sat = 0.
- History:
  - Shift register of the last TAP accepted samples.
  - Shifts only on x_vld=1, so cycles with x_vld=0 are bubbles that do not enter the history.
  - Pre-reset history counts as 0.
- Function: for the n-th accepted sample, acc = sum over k=0..TAP-1 of h(k)*x(n-k), full precision in ACC_W bits.
- Pipeline, fixed 3-cycle latency. An x_vld at cycle t gives y_vld at t+3.
  - Stage 1: register the history together with a snapshot of the active bank.
  - Stage 2: register the TAP products.
  - Stage 3: sum, round, saturate and register the outputs.
  - Back-to-back x_vld gives back-to-back y_vld.
- Round/saturate:
  - If SHIFT>0: r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up, floor shift). If SHIFT=0: r = acc.
  - If r > 2^(YOUT_W-1)-1 then y_out = max, y_sat=1.
  - If r < -2^(YOUT_W-1) then y_out = min, y_sat=1.
  - Otherwise y_out = r, y_sat=0.
- Outputs when y_vld=0:
  - y_out holds its last value.
  - y_sat = 0.
- Coefficient write: coe_wr updates shadow[coe_addr] at the clock edge. It never affects the active bank.
- Swap:
  - coe_swap at cycle t loads active <= shadow at the edge ending cycle t.
  - A sample accepted in cycle t uses the OLD bank; samples from t+1 onward use the NEW bank.
  - Samples already in flight are unaffected.
- Write and swap in the same cycle: the swap copies the pre-write shadow contents. The written value lands in the shadow bank only.
- Repeated swap with no intervening writes: no change.
- Reset mid-stream:
  - All in-flight samples are discarded and y_vld drops immediately (async).
  - History and both banks return to their reset values.

Test Plan:
- Impulse, defaults: x = 1,0,0,0,0 on consecutive cycles -> y_out = 7,14,-138,129,0 with y_vld at cycles 3..7 and y_sat=0.
- Step with bubbles: x=1 on alternating cycles (x_vld toggling) -> y_out = 7,21,-117,12,12; each y_vld 3 cycles after its x_vld; bubbles produce no output.
- Rounding, SHIFT=4: impulse x=1 -> y_out = 0,1,-9,8,0.
- Saturation: write all four taps = 32767, swap, then x = -32768 four times -> fourth y_out = -16777216 with y_sat=1; earlier outputs also clip (each below -16777216).
- Swap boundary:
  - Write h = {1,0,0,0} and pulse coe_swap in the same cycle as a sample x=5 -> that sample's y_out = 35 (old h0=7).
  - The next sample x=5 -> y_out = 5.
  - Also check that a write in the swap cycle is excluded from the swap.
- Reset mid-stream: deassert rst_n while 2 outputs are in flight -> y_vld=0 at once, none of the in-flight outputs appear, and after release an impulse gives 7,14,-138,129 again.
